// File: rtl/seg7_cmd_if.sv
// Byte-strobe / tick inputs and display outputs of the 7-segment command controller.
// rx_valid is a one-clk strobe qualifying rx_data; there is no ready, so every strobe is consumed.
interface seg7_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tick_1s;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [1:0] colon;
  logic       mode;
  logic       cmd_err;

  modport master (
    output rx_data, rx_valid, tick_1s,
    input  digit0, digit1, digit2, digit3, colon, mode, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid, tick_1s,
    output digit0, digit1, digit2, digit3, colon, mode, cmd_err
  );
endinterface

// File: rtl/seg7_cmd_ctrl.sv
// Command parser, BCD seconds counter and display-source arbiter for a 4-digit
// 7-segment display; host commands take the display, inactivity hands it back.
module seg7_cmd_ctrl #(
  parameter logic [15:0] GAP_CYCLES   = 16'd16000,
  parameter logic [7:0]  HOST_TIMEOUT = 8'd5
) (
  input  logic        clk,
  input  logic        reset,
  seg7_cmd_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIG_HI  = 2'd1,
    DIG_LO  = 2'd2,
    COL_ARG = 2'd3
  } state_e;

  state_e            state, state_nxt;
  logic [15:0]       gap_cnt, gap_nxt;
  logic              err_nxt;
  logic              stage_ld;
  logic              dig_commit;
  logic              col_commit;
  logic              release_cmd;
  logic              clear_cmd;
  logic              gap_expire;

  logic [7:0]        stage_hi;
  logic [15:0]       host_dig;
  logic [1:0]        host_colon;
  logic [3:0][3:0]   bcd;
  logic [3:0][3:0]   bcd_inc;
  logic              carry;
  logic              mode_q;
  logic [7:0]        idle_cnt;

  logic [15:0]       digits_q;
  logic [1:0]        colon_q;
  logic              cmd_err_q;

  assign dbg_state = state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // A byte arriving on the expiry cycle never increments the timer, so it wins.
  assign gap_expire = !bus.rx_valid && (gap_cnt == GAP_CYCLES - 16'd1);

  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    err_nxt     = 1'b0;
    stage_ld    = 1'b0;
    dig_commit  = 1'b0;
    col_commit  = 1'b0;
    release_cmd = 1'b0;
    clear_cmd   = 1'b0;
    case (state)
      IDLE: begin
        gap_nxt = 16'd0;
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h80:   state_nxt   = DIG_HI;
            8'h90:   state_nxt   = COL_ARG;
            8'hA0:   release_cmd = 1'b1;
            8'hB0:   clear_cmd   = 1'b1;
            default: err_nxt     = 1'b1;
          endcase
        end
      end
      DIG_HI, DIG_LO, COL_ARG: begin
        if (bus.rx_valid) begin
          gap_nxt = 16'd0;
          case (state)
            DIG_HI: begin
              stage_ld  = 1'b1;
              state_nxt = DIG_LO;
            end
            DIG_LO: begin
              dig_commit = 1'b1;
              state_nxt  = IDLE;
            end
            default: begin
              col_commit = 1'b1;
              state_nxt  = IDLE;
            end
          endcase
        end else if (gap_expire) begin
          err_nxt   = 1'b1;
          gap_nxt   = 16'd0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- host registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_hi   <= 8'd0;
      host_dig   <= 16'd0;
      host_colon <= 2'b00;
    end else begin
      if (stage_ld)   stage_hi   <= bus.rx_data;
      if (dig_commit) host_dig   <= {stage_hi, bus.rx_data};
      if (col_commit) host_colon <= bus.rx_data[1:0];
    end
  end

  // ---------------------------------------------------------------- BCD counter
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            bcd <= '0;
    else if (clear_cmd)   bcd <= '0;
    else if (bus.tick_1s) bcd <= bcd_inc;
  end

  // ---------------------------------------------------------------- ownership
  // A completed command beats a same-cycle timeout; release also clears idle time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= 1'b0;
      idle_cnt <= 8'd0;
    end else if (dig_commit || col_commit) begin
      mode_q   <= 1'b1;
      idle_cnt <= 8'd0;
    end else if (release_cmd) begin
      mode_q   <= 1'b0;
      idle_cnt <= 8'd0;
    end else if (mode_q && (HOST_TIMEOUT != 8'd0) && bus.tick_1s) begin
      if (idle_cnt == HOST_TIMEOUT - 8'd1) begin
        mode_q   <= 1'b0;
        idle_cnt <= 8'd0;
      end else begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------- output mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q  <= 16'd0;
      colon_q   <= 2'b11;
      cmd_err_q <= 1'b0;
    end else begin
      digits_q  <= mode_q ? host_dig : bcd;
      colon_q   <= mode_q ? host_colon : 2'b11;
      cmd_err_q <= err_nxt;
    end
  end

  assign bus.digit0  = digits_q[3:0];
  assign bus.digit1  = digits_q[7:4];
  assign bus.digit2  = digits_q[11:8];
  assign bus.digit3  = digits_q[15:12];
  assign bus.colon   = colon_q;
  assign bus.mode    = mode_q;
  assign bus.cmd_err = cmd_err_q;

endmodule

// File: tb/tb_seg7_cmd_ctrl.sv
// Bench for seg7_cmd_ctrl: directed scenarios plus random traffic, every cycle's
// outputs checked against a queue filled by an integer-level reference model.
module tb_seg7_cmd_ctrl;
  localparam int GAP = 20;
  localparam int HTO = 5;

  // ---------------------------------------------------------------- clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  seg7_cmd_if bus();

  seg7_cmd_ctrl #(
    .GAP_CYCLES  (16'(GAP)),
    .HOST_TIMEOUT(8'(HTO))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tick_1s  = 1'b0;
  end

  // ---------------------------------------------------------------- reference model
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  int          m_cnt, m_idle, m_gap, m_pend;   // m_pend: 0 none, 1 want hi, 2 want lo, 3 want colon
  logic        m_mode, m_err;
  logic [7:0]  m_hi;
  logic [15:0] m_host, m_disp;
  logic [1:0]  m_hcol, m_col;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model(input logic rv, input logic [7:0] rd, input logic tk, input logic rs);
    logic [15:0] nd;
    logic [1:0]  nc;
    logic        done, rel, clr;
    if (rs) begin
      m_cnt = 0; m_idle = 0; m_gap = 0; m_pend = 0;
      m_mode = 1'b0; m_err = 1'b0; m_hi = 8'h00; m_host = 16'h0000;
      m_hcol = 2'b00; m_disp = 16'h0000; m_col = 2'b11;
      return;
    end
    nd = m_mode ? m_host : to_bcd(m_cnt);
    nc = m_mode ? m_hcol : 2'b11;
    m_err = 1'b0; done = 1'b0; rel = 1'b0; clr = 1'b0;
    if (m_pend == 0) begin
      if (rv) begin
        case (rd)
          8'h80:   begin m_pend = 1; m_gap = 0; end
          8'h90:   begin m_pend = 3; m_gap = 0; end
          8'hA0:   rel = 1'b1;
          8'hB0:   clr = 1'b1;
          default: m_err = 1'b1;
        endcase
      end
    end else if (rv) begin
      m_gap = 0;
      if (m_pend == 1) begin
        m_hi = rd; m_pend = 2;
      end else if (m_pend == 2) begin
        m_host = {m_hi, rd}; done = 1'b1; m_pend = 0;
      end else begin
        m_hcol = rd[1:0]; done = 1'b1; m_pend = 0;
      end
    end else begin
      m_gap++;
      if (m_gap == GAP) begin
        m_err = 1'b1; m_pend = 0; m_gap = 0;
      end
    end
    if (clr)     m_cnt = 0;
    else if (tk) m_cnt = (m_cnt + 1) % 10000;
    if (done) begin
      m_mode = 1'b1; m_idle = 0;
    end else if (rel) begin
      m_mode = 1'b0; m_idle = 0;
    end else if (m_mode && HTO != 0 && tk) begin
      m_idle++;
      if (m_idle == HTO) begin
        m_mode = 1'b0; m_idle = 0;
      end
    end
    m_disp = nd;
    m_col  = nc;
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input logic rv, input logic [7:0] rd, input logic tk, input logic rs);
    @(negedge clk);
    reset        = rs;
    bus.rx_valid = rv;
    bus.rx_data  = rd;
    bus.tick_1s  = tk;
    model(rv, rd, tk, rs);
    exp_q.push_back({m_disp, m_col, m_mode, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------- scoreboard monitor
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [19:0] mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("digits",  {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, mon_e[19:4]);
      chk("colon",   16'(bus.colon),   16'(mon_e[3:2]));
      chk("mode",    16'(bus.mode),    16'(mon_e[1]));
      chk("cmd_err", 16'(bus.cmd_err), 16'(mon_e[0]));
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int pick;
    logic [7:0] b;
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Seconds counter: 12 ticks, then up to 9999 and wrap.
    for (int i = 0; i < 12; i++) begin tick(); idle(1); end
    idle(3);
    for (int i = 0; i < 9987; i++) tick();
    idle(2);
    tick();
    idle(3);

    // SET_DIGITS back to back.
    send(8'h80); send(8'h12); send(8'h34);
    idle(4);

    // Gap expiry mid SET_DIGITS, then SET_COLON.
    send(8'h80); send(8'h56);
    idle(GAP + 3);
    send(8'h90); send(8'h01);
    idle(3);

    // Byte arriving exactly on the expiry cycle is accepted.
    send(8'h90); idle(GAP - 1); send(8'h02);
    idle(3);

    // Host timeout, then a restart of the timeout by a new command.
    for (int i = 0; i < 5; i++) begin tick(); idle(2); end
    send(8'h90); send(8'h03);
    for (int i = 0; i < 3; i++) begin tick(); idle(1); end
    send(8'h90); send(8'h00);
    for (int i = 0; i < 4; i++) begin tick(); idle(1); end
    idle(2);
    tick();
    idle(3);

    // Completion coinciding with the timeout tick.
    send(8'h90); send(8'h01);
    for (int i = 0; i < 4; i++) begin tick(); idle(1); end
    send(8'h90); step(1'b1, 8'h03, 1'b1, 1'b0);
    idle(3);

    // Invalid opcode, CLEAR with tick, RELEASE with tick.
    send(8'h7F);
    idle(2);
    for (int i = 0; i < 7; i++) tick();
    step(1'b1, 8'hB0, 1'b1, 1'b0);
    idle(3);
    send(8'h80); send(8'hAB); send(8'hCD);
    idle(2);
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    idle(3);

    // Reset mid command; trailing byte becomes an invalid opcode.
    send(8'h80); send(8'h12);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    send(8'h34);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) idle(GAP + 2);
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1:    b = 8'h80;
        2, 3:    b = 8'h90;
        4:       b = 8'hA0;
        5:       b = 8'hB0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 2) == 0, b, $urandom_range(0, 7) == 0,
           $urandom_range(0, 599) == 0);
    end
    idle(4);

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
